// File: rtl/data_bus_arbiter.sv
// -----------------------------------------------------------------------------
// data_bus_arbiter
//
// Shares the core's single data-memory port (req/gnt/rvalid protocol) between
// two requesters: master 0 (the EX-stage LSU) and master 1 (an auxiliary agent
// such as debug or DMA). Arbitration is round-robin. A selection that has been
// presented to memory but not yet granted stays locked until it is granted.
// Granted transactions are tracked in a small ID FIFO so that every response
// is routed back to the master that issued it.
//
// Parameters:
//   MAX_OUTSTANDING  granted-but-unanswered transactions allowed (1..4)
//   CNT_W            width of the outstanding counter (derived, do not override)
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   mX_req_i / mX_gnt_o       master X request / grant (grant is combinational)
//   mX_addr_i, mX_we_i,
//   mX_be_i, mX_wdata_i       master X transaction attributes
//   mX_rvalid_o, mX_rdata_o   master X response (rdata is broadcast; qualify
//                             it with the master's own rvalid)
//   data_*                    memory-side req/gnt/rvalid port
//   busy_o                    at least one transaction outstanding
//   rsp_err_o                 data_rvalid_i seen with nothing outstanding
//
// All outputs are forced to 0 while rst_ni is low, including the purely
// combinational paths from the master and memory inputs.
// -----------------------------------------------------------------------------
module data_bus_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        m0_req_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    input  logic [31:0] m0_addr_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_wdata_i,
    output logic [31:0] m0_rdata_o,

    input  logic        m1_req_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    input  logic [31:0] m1_addr_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_wdata_i,
    output logic [31:0] m1_rdata_o,

    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,

    output logic        busy_o,
    output logic        rsp_err_o
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    // Lock FSM encoding
    localparam logic [0:0] UNLOCKED = 1'b0;
    localparam logic [0:0] LOCKED   = 1'b1;

    logic [0:0]       lock_state;
    logic             lock_id;     // master held while locked
    logic             rr_ptr;      // master favoured when both request
    logic             sel;         // currently selected master
    logic             sel_req;
    logic             can_issue;
    logic             handshake;
    logic             pop;
    logic             has_out;
    logic             head;        // master that owns the oldest outstanding txn
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             id_fifo [MAX_OUTSTANDING];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // -------------------------------------------------------------------------
    // Selection
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        sel = rr_ptr;
        if (lock_state == LOCKED) begin
            sel = lock_id;
        end else if (m0_req_i && !m1_req_i) begin
            sel = 1'b0;
        end else if (m1_req_i && !m0_req_i) begin
            sel = 1'b1;
        end
    end

    assign sel_req   = sel ? m1_req_i : m0_req_i;
    // The count is the registered value, so a response arriving this cycle
    // does not open a slot until the next one.
    assign can_issue = (count < CNT_MAX);
    assign data_req_o = rst_ni && sel_req && can_issue;
    assign handshake  = data_req_o && data_gnt_i;

    assign m0_gnt_o = handshake && !sel;
    assign m1_gnt_o = handshake &&  sel;

    always_comb begin
        data_addr_o  = '0;
        data_we_o    = 1'b0;
        data_be_o    = '0;
        data_wdata_o = '0;
        if (rst_ni && sel_req) begin
            if (sel) begin
                data_addr_o  = m1_addr_i;
                data_we_o    = m1_we_i;
                data_be_o    = m1_be_i;
                data_wdata_o = m1_wdata_i;
            end else begin
                data_addr_o  = m0_addr_i;
                data_we_o    = m0_we_i;
                data_be_o    = m0_be_i;
                data_wdata_o = m0_wdata_i;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Lock FSM and round-robin pointer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: flop state is written with non-blocking assignments so every
        // block in this module sees the pre-edge values regardless of order.
        if (!rst_ni) begin
            lock_state <= UNLOCKED;
            lock_id    <= 1'b0;
            rr_ptr     <= 1'b0;
        end else begin
            if (lock_state == UNLOCKED) begin
                if (data_req_o && !data_gnt_i) begin
                    lock_state <= LOCKED;
                    lock_id    <= sel;
                end
            end else begin
                // A locked master that drops its request is a protocol error;
                // unlocking anyway keeps the other master from starving.
                if (handshake || !sel_req) begin
                    lock_state <= UNLOCKED;
                end
            end
            if (handshake) begin
                rr_ptr <= ~sel;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outstanding-transaction tracking
    // -------------------------------------------------------------------------
    assign has_out = (count != '0);
    assign head    = id_fifo[rd_ptr];
    assign pop     = data_rvalid_i && has_out;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (handshake) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (handshake && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !handshake) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // NOTE: the ID storage has no reset; an entry is only read after the
    // pointers mark it valid, and leaving it unreset keeps it plain flops.
    always_ff @(posedge clk_i) begin
        if (handshake) begin
            id_fifo[wr_ptr] <= sel;
        end
    end

    // -------------------------------------------------------------------------
    // Response routing
    // -------------------------------------------------------------------------
    assign m0_rvalid_o = pop && !head;
    assign m1_rvalid_o = pop &&  head;
    assign m0_rdata_o  = rst_ni ? data_rdata_i : '0;
    assign m1_rdata_o  = rst_ni ? data_rdata_i : '0;
    assign busy_o      = has_out;
    assign rsp_err_o   = rst_ni && data_rvalid_i && !has_out;

    // A locked master must keep its request up until it is granted.
    lock_hold_req: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (lock_state == LOCKED) |-> sel_req
    );

endmodule

// File: tb/tb_data_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_bus_arbiter
//
// Self-checking bench for data_bus_arbiter (MAX_OUTSTANDING = 2). Each issued
// transaction pushes the expected {master, response data} onto a scoreboard;
// when the bench plays the memory response, the front entry is popped and the
// DUT's routing and data are compared against it. Inputs change 1 ns after
// the rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_data_bus_arbiter;

    logic        clk_i  = 1'b0;
    logic        rst_ni = 1'b1;

    logic        m0_req_i = 1'b0, m1_req_i = 1'b0;
    logic [31:0] m0_addr_i = '0, m1_addr_i = '0;
    logic        m0_we_i = 1'b0, m1_we_i = 1'b0;
    logic [3:0]  m0_be_i = '0, m1_be_i = '0;
    logic [31:0] m0_wdata_i = '0, m1_wdata_i = '0;
    logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;

    logic        data_req_o, data_we_o;
    logic        data_gnt_i = 1'b0, data_rvalid_i = 1'b0;
    logic [31:0] data_addr_o, data_wdata_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_rdata_i = '0;
    logic        busy_o, rsp_err_o;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    logic exp_ptr = 1'b0;   // model of the round-robin pointer

    data_bus_arbiter #(.MAX_OUTSTANDING(2)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .m0_req_i     (m0_req_i),
        .m0_gnt_o     (m0_gnt_o),
        .m0_rvalid_o  (m0_rvalid_o),
        .m0_addr_i    (m0_addr_i),
        .m0_we_i      (m0_we_i),
        .m0_be_i      (m0_be_i),
        .m0_wdata_i   (m0_wdata_i),
        .m0_rdata_o   (m0_rdata_o),
        .m1_req_i     (m1_req_i),
        .m1_gnt_o     (m1_gnt_o),
        .m1_rvalid_o  (m1_rvalid_o),
        .m1_addr_i    (m1_addr_i),
        .m1_we_i      (m1_we_i),
        .m1_be_i      (m1_be_i),
        .m1_wdata_i   (m1_wdata_i),
        .m1_rdata_o   (m1_rdata_o),
        .data_req_o   (data_req_o),
        .data_gnt_i   (data_gnt_i),
        .data_rvalid_i(data_rvalid_i),
        .data_addr_o  (data_addr_o),
        .data_we_o    (data_we_o),
        .data_be_o    (data_be_o),
        .data_wdata_o (data_wdata_o),
        .data_rdata_i (data_rdata_i),
        .busy_o       (busy_o),
        .rsp_err_o    (rsp_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic next_cycle;
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs;
        m0_req_i = 1'b0; m0_addr_i = '0; m0_we_i = 1'b0; m0_be_i = '0; m0_wdata_i = '0;
        m1_req_i = 1'b0; m1_addr_i = '0; m1_we_i = 1'b0; m1_be_i = '0; m1_wdata_i = '0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
    endtask

    function automatic exp_t mk(input logic id, input logic [31:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        return e;
    endfunction

    // Memory returns the data of the oldest expected transaction.
    task automatic play_rsp;
        data_rvalid_i = 1'b1;
        data_rdata_i  = (sb.size() > 0) ? sb[0].data : 32'h0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset;
        rst_ni = 1'b0;
        m0_req_i = 1'b1; m0_addr_i = 32'h55; m0_we_i = 1'b1; m0_be_i = 4'hF; m0_wdata_i = 32'hABCD;
        m1_req_i = 1'b1; m1_addr_i = 32'h66;
        data_gnt_i = 1'b1; data_rvalid_i = 1'b1; data_rdata_i = 32'h1234_5678;
        @(negedge clk_i);
        total++;
        if ({data_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, busy_o, rsp_err_o} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl: req/g0/g1/rv0/rv1/busy/err=%b required 0000000",
                     {data_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, busy_o, rsp_err_o});
        end
        total++;
        if ({data_addr_o, data_we_o, data_be_o, data_wdata_o} !== 69'h0) begin
            bad++;
            $display("FAIL reset_bus: addr=%h we=%b be=%h wdata=%h required all 0",
                     data_addr_o, data_we_o, data_be_o, data_wdata_o);
        end
        total++;
        if ({m0_rdata_o, m1_rdata_o} !== 64'h0) begin
            bad++;
            $display("FAIL reset_rdata: m0=%h m1=%h required 0", m0_rdata_o, m1_rdata_o);
        end
        clear_inputs();
        next_cycle();
        rst_ni  = 1'b1;
        exp_ptr = 1'b0;
        sb.delete();
        next_cycle();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_round_robin;
        exp_t e;
        m0_addr_i = 32'h200;
        m1_addr_i = 32'h300;
        for (int i = 0; i < 5; i++) begin
            m0_req_i   = (i < 4);
            m1_req_i   = (i < 4);
            data_gnt_i = (i < 4);
            data_rvalid_i = 1'b0;
            if (i > 0) play_rsp();
            @(negedge clk_i);
            if (i > 0) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL rr_sb: response %0d with no expected entry", i);
                end else begin
                    e = sb.pop_front();
                    total++;
                    if ({m1_rvalid_o, m0_rvalid_o} !== (e.id ? 2'b10 : 2'b01)) begin
                        bad++;
                        $display("FAIL rr_route[%0d]: rvalid m1m0=%b required %b", i,
                                 {m1_rvalid_o, m0_rvalid_o}, (e.id ? 2'b10 : 2'b01));
                    end
                    if ((e.id ? m1_rdata_o : m0_rdata_o) !== e.data) begin
                        bad++;
                        $display("FAIL rr_rdata[%0d]: got %h required %h", i,
                                 (e.id ? m1_rdata_o : m0_rdata_o), e.data);
                    end
                end
            end
            if (i < 4) begin
                total++;
                if ({m1_gnt_o, m0_gnt_o} !== (exp_ptr ? 2'b10 : 2'b01) ||
                    data_addr_o !== (exp_ptr ? 32'h300 : 32'h200)) begin
                    bad++;
                    $display("FAIL rr_gnt[%0d]: gnt m1m0=%b addr=%h required m%0d", i,
                             {m1_gnt_o, m0_gnt_o}, data_addr_o, exp_ptr);
                end
                sb.push_back(mk(exp_ptr, 32'hA000_0000 + 32'(i)));
                exp_ptr = ~exp_ptr;
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_lock;
        exp_t e;
        m1_req_i = 1'b1; m1_addr_i = 32'h400; m1_we_i = 1'b1; m1_be_i = 4'h3; m1_wdata_i = 32'hCAFE;
        data_gnt_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                m0_req_i  = 1'b1;
                m0_addr_i = 32'h500;
            end
            @(negedge clk_i);
            total++;
            if ({data_req_o, m0_gnt_o, m1_gnt_o, data_addr_o} !== {3'b100, 32'h400}) begin
                bad++;
                $display("FAIL lock_hold[%0d]: req=%b g0=%b g1=%b addr=%h required 1 0 0 00000400",
                         c, data_req_o, m0_gnt_o, m1_gnt_o, data_addr_o);
            end
            next_cycle();
        end
        data_gnt_i = 1'b1;
        @(negedge clk_i);
        total++;
        if ({m1_gnt_o, m0_gnt_o, data_addr_o, data_we_o, data_wdata_o, data_be_o} !==
            {2'b10, 32'h400, 1'b1, 32'hCAFE, 4'h3}) begin
            bad++;
            $display("FAIL lock_gnt_m1: g1g0=%b addr=%h we=%b wdata=%h be=%h required 10 400 1 cafe 3",
                     {m1_gnt_o, m0_gnt_o}, data_addr_o, data_we_o, data_wdata_o, data_be_o);
        end
        sb.push_back(mk(1'b1, 32'h4444));
        exp_ptr = 1'b0;
        next_cycle();
        m1_req_i = 1'b0; m1_we_i = 1'b0;
        play_rsp();
        @(negedge clk_i);
        total++;
        if ({m1_gnt_o, m0_gnt_o, data_addr_o} !== {2'b01, 32'h500}) begin
            bad++;
            $display("FAIL lock_gnt_m0: g1g0=%b addr=%h required 01 00000500",
                     {m1_gnt_o, m0_gnt_o}, data_addr_o);
        end
        e = sb.pop_front();
        total++;
        if ({m1_rvalid_o, m0_rvalid_o} !== 2'b10 || m1_rdata_o !== e.data) begin
            bad++;
            $display("FAIL lock_rsp_m1: rvalid m1m0=%b rdata=%h required 10 %h",
                     {m1_rvalid_o, m0_rvalid_o}, m1_rdata_o, e.data);
        end
        sb.push_back(mk(1'b0, 32'h5555));
        exp_ptr = 1'b1;
        next_cycle();
        m0_req_i = 1'b0; data_gnt_i = 1'b0;
        play_rsp();
        @(negedge clk_i);
        e = sb.pop_front();
        total++;
        if ({m1_rvalid_o, m0_rvalid_o} !== 2'b01 || m0_rdata_o !== e.data) begin
            bad++;
            $display("FAIL lock_rsp_m0: rvalid m1m0=%b rdata=%h required 01 %h",
                     {m1_rvalid_o, m0_rvalid_o}, m0_rdata_o, e.data);
        end
        next_cycle();
        clear_inputs();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_single;
        exp_t e;
        m0_req_i = 1'b1; m0_addr_i = 32'h100; m0_be_i = 4'hF; data_gnt_i = 1'b1;
        @(negedge clk_i);
        total++;
        if ({data_req_o, m0_gnt_o, m1_gnt_o, busy_o, data_addr_o} !== {4'b1100, 32'h100}) begin
            bad++;
            $display("FAIL single_gnt: req=%b g0=%b g1=%b busy=%b addr=%h required 1 1 0 0 00000100",
                     data_req_o, m0_gnt_o, m1_gnt_o, busy_o, data_addr_o);
        end
        sb.push_back(mk(1'b0, 32'hDEAD_BEEF));
        exp_ptr = 1'b1;
        next_cycle();
        m0_req_i = 1'b0; data_gnt_i = 1'b0;
        play_rsp();
        @(negedge clk_i);
        e = sb.pop_front();
        total++;
        if ({m1_rvalid_o, m0_rvalid_o} !== 2'b01 || m0_rdata_o !== e.data || busy_o !== 1'b1) begin
            bad++;
            $display("FAIL single_rsp: rvalid m1m0=%b rdata=%h busy=%b required 01 %h 1",
                     {m1_rvalid_o, m0_rvalid_o}, m0_rdata_o, busy_o, e.data);
        end
        next_cycle();
        data_rvalid_i = 1'b0;
        @(negedge clk_i);
        total++;
        if ({busy_o, m0_rvalid_o, m1_rvalid_o} !== 3'b000) begin
            bad++;
            $display("FAIL single_idle: busy=%b rv0=%b rv1=%b required 000",
                     busy_o, m0_rvalid_o, m1_rvalid_o);
        end
        next_cycle();
        clear_inputs();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_outstanding;
        exp_t e;
        logic [31:0] addrs [5];
        logic        exp_req [5];
        logic        rsp [5];
        addrs   = '{32'h600, 32'h604, 32'h608, 32'h608, 32'h608};
        exp_req = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        rsp     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int c = 0; c < 6; c++) begin
            m0_req_i   = (c < 5);
            data_gnt_i = (c < 5);
            m0_addr_i  = (c < 5) ? addrs[c] : 32'h0;
            data_rvalid_i = 1'b0;
            if (c == 5 || rsp[c]) play_rsp();
            @(negedge clk_i);
            if (c < 5) begin
                total++;
                if ({data_req_o, m0_gnt_o} !== {exp_req[c], exp_req[c]}) begin
                    bad++;
                    $display("FAIL limit_issue[%0d]: req=%b g0=%b required %b", c,
                             data_req_o, m0_gnt_o, exp_req[c]);
                end
            end
            if (c == 5 || rsp[c]) begin
                e = sb.pop_front();
                total++;
                if ({m1_rvalid_o, m0_rvalid_o} !== 2'b01 || m0_rdata_o !== e.data) begin
                    bad++;
                    $display("FAIL limit_rsp[%0d]: rvalid m1m0=%b rdata=%h required 01 %h", c,
                             {m1_rvalid_o, m0_rvalid_o}, m0_rdata_o, e.data);
                end
            end
            if (c < 5 && exp_req[c]) begin
                sb.push_back(mk(1'b0, 32'h6000 + 32'(c)));
                exp_ptr = 1'b1;
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_mix;
        exp_t e;
        m0_req_i = 1'b1; m0_addr_i = 32'h700; data_gnt_i = 1'b1;
        @(negedge clk_i);
        total++;
        if ({m1_gnt_o, m0_gnt_o} !== 2'b01) begin
            bad++;
            $display("FAIL mix_gnt_m0: g1g0=%b required 01", {m1_gnt_o, m0_gnt_o});
        end
        sb.push_back(mk(1'b0, 32'h11));
        next_cycle();
        m0_req_i = 1'b0; m1_req_i = 1'b1; m1_addr_i = 32'h704;
        @(negedge clk_i);
        total++;
        if ({m1_gnt_o, m0_gnt_o} !== 2'b10) begin
            bad++;
            $display("FAIL mix_gnt_m1: g1g0=%b required 10", {m1_gnt_o, m0_gnt_o});
        end
        sb.push_back(mk(1'b1, 32'h22));
        next_cycle();
        m1_req_i = 1'b0; data_gnt_i = 1'b0;
        for (int r = 0; r < 2; r++) begin
            play_rsp();
            @(negedge clk_i);
            e = sb.pop_front();
            total++;
            if ({m1_rvalid_o, m0_rvalid_o} !== (e.id ? 2'b10 : 2'b01) ||
                (e.id ? m1_rdata_o : m0_rdata_o) !== e.data) begin
                bad++;
                $display("FAIL mix_rsp[%0d]: rvalid m1m0=%b rdata=%h required m%0d %h", r,
                         {m1_rvalid_o, m0_rvalid_o}, (e.id ? m1_rdata_o : m0_rdata_o), e.id, e.data);
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_error_reset;
        data_rvalid_i = 1'b1; data_rdata_i = 32'h77;
        @(negedge clk_i);
        total++;
        if ({rsp_err_o, m0_rvalid_o, m1_rvalid_o, busy_o} !== 4'b1000) begin
            bad++;
            $display("FAIL err_pulse: err/rv0/rv1/busy=%b required 1000",
                     {rsp_err_o, m0_rvalid_o, m1_rvalid_o, busy_o});
        end
        next_cycle();
        data_rvalid_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (rsp_err_o !== 1'b0) begin
            bad++;
            $display("FAIL err_one_cycle: err=%b required 0", rsp_err_o);
        end
        next_cycle();
        m0_req_i = 1'b1; m0_addr_i = 32'h800; data_gnt_i = 1'b1;
        @(negedge clk_i);
        total++;
        if (m0_gnt_o !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre_gnt: g0=%b required 1", m0_gnt_o);
        end
        sb.push_back(mk(1'b0, 32'h88));
        next_cycle();
        m0_req_i = 1'b0; data_gnt_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (busy_o !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre_busy: busy=%b required 1", busy_o);
        end
        // Reset lands mid-cycle with live stimulus on every input.
        rst_ni = 1'b0;
        sb.delete();
        exp_ptr = 1'b0;
        m1_req_i = 1'b1; m1_addr_i = 32'h900; m1_wdata_i = 32'h9999; m1_be_i = 4'hF;
        data_gnt_i = 1'b1; data_rvalid_i = 1'b1; data_rdata_i = 32'h99;
        #1;
        total++;
        if ({data_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, busy_o, rsp_err_o} !== 7'b0) begin
            bad++;
            $display("FAIL rst_mid_ctrl: req/g0/g1/rv0/rv1/busy/err=%b required 0000000",
                     {data_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, busy_o, rsp_err_o});
        end
        total++;
        if ({data_addr_o, data_we_o, data_be_o, data_wdata_o, m0_rdata_o, m1_rdata_o} !== 133'h0) begin
            bad++;
            $display("FAIL rst_mid_data: addr=%h wdata=%h be=%h rd0=%h rd1=%h required 0",
                     data_addr_o, data_wdata_o, data_be_o, m0_rdata_o, m1_rdata_o);
        end
        clear_inputs();
        next_cycle();
        rst_ni = 1'b1;
        next_cycle();
        data_rvalid_i = 1'b1; data_rdata_i = 32'h88;
        @(negedge clk_i);
        total++;
        if ({rsp_err_o, m0_rvalid_o, m1_rvalid_o} !== 3'b100) begin
            bad++;
            $display("FAIL rst_stale_rsp: err/rv0/rv1=%b required 100",
                     {rsp_err_o, m0_rvalid_o, m1_rvalid_o});
        end
        next_cycle();
        clear_inputs();
    endtask

    // -------------------------------------------------------------------------
    initial begin
        #1;
        test_reset();
        test_round_robin();
        test_lock();
        test_single();
        test_outstanding();
        test_mix();
        test_error_reset();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: %0d expected responses never checked, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
Shares the single core data-memory port (req/gnt/rvalid protocol) between two requesters. Master 0 is the EX-stage LSU. Master 1 is an auxiliary agent such as a debug or DMA port. The block sits between ex_stage and the data memory/bus. It arbitrates round-robin, locks a selection until it is granted, tracks outstanding transactions, and routes each response back to the master that issued it.

Parameters:
MAX_OUTSTANDING, 2, maximum granted-but-unanswered transactions in flight (1..4).
CNT_W, $clog2(MAX_OUTSTANDING+1), width of the outstanding counter (derived; do not override).

Ports:
clk_i  in  1  core clock
rst_ni  in  1  reset, asynchronous, active-low
m0_req_i  in  1  LSU request
m0_gnt_o  out  1  LSU grant
m0_rvalid_o  out  1  LSU response valid
m0_addr_i  in  32  LSU address
m0_we_i  in  1  LSU write enable
m0_be_i  in  4  LSU byte enables
m0_wdata_i  in  32  LSU write data
m0_rdata_o  out  32  LSU read data
m1_req_i / m1_gnt_o / m1_rvalid_o / m1_addr_i / m1_we_i / m1_be_i / m1_wdata_i / m1_rdata_o  same directions and widths as m0, for master 1
data_req_o  out  1  request to memory
data_gnt_i  in  1  memory grant
data_rvalid_i  in  1  memory response valid
data_addr_o  out  32  address to memory
data_we_o  out  1  write enable to memory
data_be_o  out  4  byte enables to memory
data_wdata_o  out  32  write data to memory
data_rdata_i  in  32  read data from memory
busy_o  out  1  at least one transaction outstanding
rsp_err_o  out  1  one-cycle pulse: data_rvalid_i arrived with nothing outstanding

Behaviour:
- Reset (async, rst_ni=0):
  - Priority pointer resets to m0; lock is cleared; ID FIFO and counter are emptied.
  - Every output is 0: data_req_o, both gnt, both rvalid, busy_o, rsp_err_o, data_addr_o/we/be/wdata, both rdata.
- Reset mid-operation: in-flight transactions are discarded. A later data_rvalid_i for a discarded transaction raises rsp_err_o and is not forwarded to either master.
- Selection (combinational):
  - If locked, sel = the locked master.
  - Otherwise, if only one master requests, sel = that master.
  - If both request, sel = the pointer.
- Issue gating: can_issue = (count < MAX_OUTSTANDING). Count is sampled before any same-cycle pop; a response arriving in the same cycle does not free a slot for that cycle.
- Memory-side outputs:
  - data_req_o = sel master's req && can_issue.
  - addr/we/be/wdata mux from sel; they are 0 when no master requests.
- Grant: mX_gnt_o = data_gnt_i && data_req_o && sel==X. The grant path is zero-latency (combinational).
- Lock FSM, states UNLOCKED and LOCKED:
  - UNLOCKED -> LOCKED(sel) when data_req_o=1 and data_gnt_i=0.
  - LOCKED -> UNLOCKED on the handshake (data_req_o && data_gnt_i).
  - A locked master may not be preempted.
  - A master may not drop req while locked (protocol rule). An assertion flags a violation; the RTL still unlocks on the drop.
- Pointer: on every handshake the pointer is set to the master that was not served. With both masters continuously requesting, the grant sequence strictly alternates.
- Response tracking:
  - An ID FIFO of depth MAX_OUTSTANDING, 1 bit per entry, plus a CNT_W-bit counter.
  - Push sel on each handshake; pop on data_rvalid_i when count>0.
  - A simultaneous push and pop leaves count unchanged.
  - The FIFO pointers wrap modulo MAX_OUTSTANDING.
- Response routing:
  - mX_rvalid_o = data_rvalid_i && count>0 && head==X.
  - Both mX_rdata_o = data_rdata_i (broadcast); a master qualifies it with its own rvalid.
- The memory must not assert rvalid in the same cycle as the gnt of that transaction; the earliest allowed response is one cycle later. If data_rvalid_i=1 and count==0, rsp_err_o pulses and nothing is popped or routed.
- busy_o = (count != 0), registered view of the counter.

Test Plan:
1. Single master, zero wait: m0 reads A=0x100; gnt same cycle; rvalid next cycle with 0xDEADBEEF -> m0_gnt_o=1 in cycle 0, m0_rvalid_o=1 with m0_rdata_o=0xDEADBEEF in cycle 1, m1_rvalid_o=0 throughout, busy_o high for exactly 1 cycle.
2. Contention, round-robin: both masters request continuously, gnt always 1, rvalid 1 cycle later -> grants m0,m1,m0,m1; rvalids route in the same order; no master is granted twice in a row.
3. Lock under backpressure: m1 requests alone with gnt held low 3 cycles; m0 raises req in cycle 1 -> data_addr_o stays m1's address until the grant in cycle 3, m1 is granted first, then m0.
4. Outstanding limit: with MAX_OUTSTANDING=2, two grants with no rvalid -> the third request sees data_req_o=0 until an rvalid. Response and request in the same cycle at count=2 -> no issue that cycle; issue on the next cycle.
5. Out-of-order master mix: issue m0,m1 back-to-back, responses 0x11 then 0x22 -> m0 receives 0x11 and m1 receives 0x22.
6. Error and reset: rvalid with count 0 -> rsp_err_o=1 for one cycle, no mX_rvalid_o. Assert rst_ni low mid-transaction with count=1 -> all outputs 0 immediately; a post-reset rvalid -> rsp_err_o pulse.
